// File: rtl/mbldcm_avmm_if_mc_if.sv
// Avalon-MM slave bus bundle for the mBldcm multi-channel register block.
// A read or write is accepted on every rising clock edge where iRead or iWrite is high; there is
// no wait request. Read data, oResp and oRdataValid appear one cycle after acceptance. Writes return nothing.
interface mbldcm_avmm_if_mc_if;
    logic [4:0]  iAddr;
    logic        iRead;
    logic        iWrite;
    logic [31:0] iWdata;
    logic [3:0]  iByteEn;
    logic [31:0] oRdata;
    logic        oRdataValid;
    logic [1:0]  oResp;

    modport master (
        output iAddr, iRead, iWrite, iWdata, iByteEn,
        input  oRdata, oRdataValid, oResp
    );

    modport slave (
        input  iAddr, iRead, iWrite, iWdata, iByteEn,
        output oRdata, oRdataValid, oResp
    );
endinterface

// File: rtl/mbldcm_avmm_if_mc.sv
// Multi-channel Avalon-MM register bank for mBldcm motor cores (FreqTarget, PwmCmp, Control, Status).
// Define MBLDCM_AVMM_IRQ_EN to build the sticky Status event flags and the oIrq interrupt path.
module mbldcm_avmm_if_mc #(
    parameter int pChannels = 2
) (
    input  logic                      iClock,
    input  logic                      iReset_n,
    mbldcm_avmm_if_mc_if.slave        bus,
    output logic [32*pChannels-1:0]   oFreqTarget,
    output logic [pChannels-1:0]      oLatchFreqTarget,
    output logic [17*pChannels-1:0]   oPwmCmp,
    output logic [pChannels-1:0]      oEnable,
    output logic [6*pChannels-1:0]    oPwmPrsc,
    output logic [16*pChannels-1:0]   oPwmMaxCnt,
    output logic [3*pChannels-1:0]    oPhaseUpdate,
    output logic [pChannels-1:0]      oLatchPhaseUpdate,
    input  logic [3*pChannels-1:0]    iPhase,
    input  logic [pChannels-1:0]      iFreqReflected,
    input  logic [pChannels-1:0]      iStop,
    output logic                      oIrq
);

    logic [2:0]  ch;
    logic [1:0]  word;
    logic [31:0] wmask;

    logic [31:0] freq_q   [pChannels];
    logic [31:0] freq_d   [pChannels];
    logic [16:0] pwm_q    [pChannels];
    logic [16:0] pwm_d    [pChannels];
    logic [5:0]  prsc_q   [pChannels];
    logic [5:0]  prsc_d   [pChannels];
    logic [15:0] maxcnt_q [pChannels];
    logic [15:0] maxcnt_d [pChannels];
    logic [2:0]  phase_q  [pChannels];
    logic [2:0]  phase_d  [pChannels];
    logic [pChannels-1:0] en_q, en_d;
    logic [pChannels-1:0] latch_freq_q, latch_freq_d;
    logic [pChannels-1:0] latch_phase_q, latch_phase_d;

    logic [31:0] rd_word;
    logic [1:0]  rd_resp;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  resp_q, resp_d;
    logic        rvalid_q, rvalid_d;

    logic [pChannels-1:0] irqen_q, stk_stop_q, stk_fr_q;

    assign ch    = bus.iAddr[4:2];
    assign word  = bus.iAddr[1:0];
    assign wmask = {{8{bus.iByteEn[3]}}, {8{bus.iByteEn[2]}},
                    {8{bus.iByteEn[1]}}, {8{bus.iByteEn[0]}}};

`ifdef MBLDCM_AVMM_IRQ_EN
    logic [pChannels-1:0] irqen_d, stk_stop_d, stk_fr_d;
    logic [pChannels-1:0] prev_stop_q, prev_fr_q;
    logic                 irq_q, irq_d;

    // Previous-value registers reset high so a status already asserted at reset is not an event.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            irqen_q     <= '0;
            stk_stop_q  <= '0;
            stk_fr_q    <= '0;
            prev_stop_q <= '1;
            prev_fr_q   <= '1;
            irq_q       <= 1'b0;
        end else begin
            irqen_q     <= irqen_d;
            stk_stop_q  <= stk_stop_d;
            stk_fr_q    <= stk_fr_d;
            prev_stop_q <= iStop;
            prev_fr_q   <= iFreqReflected;
            irq_q       <= irq_d;
        end
    end

    assign irq_d = |(irqen_q & (stk_stop_q | stk_fr_q));
    assign oIrq  = irq_q;
`else
    assign irqen_q    = '0;
    assign stk_stop_q = '0;
    assign stk_fr_q   = '0;
    assign oIrq       = 1'b0;
`endif

    always_comb begin
        for (int n = 0; n < pChannels; n++) begin
            freq_d[n]   = freq_q[n];
            pwm_d[n]    = pwm_q[n];
            prsc_d[n]   = prsc_q[n];
            maxcnt_d[n] = maxcnt_q[n];
            phase_d[n]  = phase_q[n];
        end
        en_d          = en_q;
        latch_freq_d  = '0;
        latch_phase_d = '0;
`ifdef MBLDCM_AVMM_IRQ_EN
        irqen_d    = irqen_q;
        stk_stop_d = stk_stop_q;
        stk_fr_d   = stk_fr_q;
`endif
        // Unmapped channels never match a loop index, so their writes fall through untouched.
        for (int n = 0; n < pChannels; n++) begin
            if (bus.iWrite && ch == 3'(n)) begin
                case (word)
                    2'd0: begin
                        freq_d[n]       = (freq_q[n] & ~wmask) | (bus.iWdata & wmask);
                        latch_freq_d[n] = |bus.iByteEn;
                    end
                    2'd1: pwm_d[n] = (pwm_q[n] & ~wmask[16:0]) | (bus.iWdata[16:0] & wmask[16:0]);
                    2'd2: begin
                        en_d[n]     = bus.iByteEn[0] ? bus.iWdata[0] : en_q[n];
                        prsc_d[n]   = (prsc_q[n] & ~wmask[11:6]) | (bus.iWdata[11:6] & wmask[11:6]);
                        maxcnt_d[n] = (maxcnt_q[n] & ~wmask[27:12]) | (bus.iWdata[27:12] & wmask[27:12]);
`ifdef MBLDCM_AVMM_IRQ_EN
                        irqen_d[n]  = bus.iByteEn[3] ? bus.iWdata[28] : irqen_q[n];
`endif
                        if (bus.iByteEn[0] && bus.iWdata[5]) begin
                            phase_d[n]       = bus.iWdata[4:2];
                            latch_phase_d[n] = 1'b1;
                        end
                    end
                    default: begin
`ifdef MBLDCM_AVMM_IRQ_EN
                        if (bus.iByteEn[0] && bus.iWdata[2]) stk_stop_d[n] = 1'b0;
                        if (bus.iByteEn[0] && bus.iWdata[3]) stk_fr_d[n]   = 1'b0;
`endif
                    end
                endcase
            end
        end
`ifdef MBLDCM_AVMM_IRQ_EN
        // Applied after the clears so a coincident new event keeps its flag.
        stk_stop_d = stk_stop_d | (iStop & ~prev_stop_q);
        stk_fr_d   = stk_fr_d | (iFreqReflected & ~prev_fr_q);
`endif
    end

    // Read mux works from current register state, so a same-cycle write is not visible yet.
    always_comb begin
        rd_word = 32'hFFFF_FFFF;
        rd_resp = 2'b11;
        for (int n = 0; n < pChannels; n++) begin
            if (ch == 3'(n)) begin
                rd_resp = 2'b00;
                case (word)
                    2'd0: rd_word = freq_q[n];
                    2'd1: rd_word = {15'd0, pwm_q[n]};
                    2'd2: rd_word = {3'd0, irqen_q[n], maxcnt_q[n], prsc_q[n], 1'b0,
                                     iPhase[3*n +: 3], 1'b0, en_q[n]};
                    default: rd_word = {28'd0, stk_fr_q[n], stk_stop_q[n],
                                        iFreqReflected[n], iStop[n]};
                endcase
            end
        end
        rvalid_d = bus.iRead;
        rdata_d  = bus.iRead ? rd_word : rdata_q;
        resp_d   = bus.iRead ? rd_resp : resp_q;
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            for (int n = 0; n < pChannels; n++) begin
                freq_q[n]   <= '0;
                pwm_q[n]    <= '0;
                prsc_q[n]   <= '0;
                maxcnt_q[n] <= 16'hFFFF;
                phase_q[n]  <= '0;
            end
            en_q          <= '0;
            latch_freq_q  <= '0;
            latch_phase_q <= '0;
            rdata_q       <= '0;
            resp_q        <= '0;
            rvalid_q      <= 1'b0;
        end else begin
            for (int n = 0; n < pChannels; n++) begin
                freq_q[n]   <= freq_d[n];
                pwm_q[n]    <= pwm_d[n];
                prsc_q[n]   <= prsc_d[n];
                maxcnt_q[n] <= maxcnt_d[n];
                phase_q[n]  <= phase_d[n];
            end
            en_q          <= en_d;
            latch_freq_q  <= latch_freq_d;
            latch_phase_q <= latch_phase_d;
            rdata_q       <= rdata_d;
            resp_q        <= resp_d;
            rvalid_q      <= rvalid_d;
        end
    end

    for (genvar g = 0; g < pChannels; g++) begin : g_out
        assign oFreqTarget[32*g +: 32] = freq_q[g];
        assign oPwmCmp[17*g +: 17]     = pwm_q[g];
        assign oPwmPrsc[6*g +: 6]      = prsc_q[g];
        assign oPwmMaxCnt[16*g +: 16]  = maxcnt_q[g];
        assign oPhaseUpdate[3*g +: 3]  = phase_q[g];
    end

    assign oEnable           = en_q;
    assign oLatchFreqTarget  = latch_freq_q;
    assign oLatchPhaseUpdate = latch_phase_q;
    assign bus.oRdata        = rdata_q;
    assign bus.oResp         = resp_q;
    assign bus.oRdataValid   = rvalid_q;

endmodule

// File: tb/tb_mbldcm_avmm_if_mc.sv
// Self-checking bench for mbldcm_avmm_if_mc with two channels; read results go through a scoreboard queue.
module tb_mbldcm_avmm_if_mc;

    localparam int CH = 2;

    logic            clk;
    logic            rst_n;
    logic [63:0]     freq_tgt;
    logic [1:0]      latch_freq;
    logic [33:0]     pwm_cmp;
    logic [1:0]      enable;
    logic [11:0]     pwm_prsc;
    logic [31:0]     pwm_maxcnt;
    logic [5:0]      phase_upd;
    logic [1:0]      latch_phase;
    logic [5:0]      phase_in;
    logic [1:0]      freq_refl;
    logic [1:0]      stop_in;
    logic            irq;

    mbldcm_avmm_if_mc_if bus ();

    mbldcm_avmm_if_mc #(.pChannels(CH)) dut (
        .iClock            (clk),
        .iReset_n          (rst_n),
        .bus               (bus),
        .oFreqTarget       (freq_tgt),
        .oLatchFreqTarget  (latch_freq),
        .oPwmCmp           (pwm_cmp),
        .oEnable           (enable),
        .oPwmPrsc          (pwm_prsc),
        .oPwmMaxCnt        (pwm_maxcnt),
        .oPhaseUpdate      (phase_upd),
        .oLatchPhaseUpdate (latch_phase),
        .iPhase            (phase_in),
        .iFreqReflected    (freq_refl),
        .iStop             (stop_in),
        .oIrq              (irq)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [33:0] exp_q[$];
    int          due_q[$];
    logic [33:0] mon_exp;
    int          mon_due;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.oRdataValid) begin
                if (exp_q.size() == 0) begin
                    check_val("rd_spurious", 64'(bus.oRdataValid), 64'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_due = due_q.pop_front();
                    check_val("rd_data", 64'(bus.oRdata), 64'(mon_exp[31:0]));
                    check_val("rd_resp", 64'(bus.oResp), 64'(mon_exp[33:32]));
                    check_val("rd_latency", 64'(cyc), 64'(mon_due));
                end
            end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
                check_val("rd_missing", 64'(bus.oRdataValid), 64'd1);
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
        end
    end

    // ---------------- drivers (called at a falling edge) ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus.iAddr   = addr;
        bus.iWdata  = data;
        bus.iByteEn = be;
        bus.iWrite  = 1'b1;
        @(negedge clk);
        bus.iWrite  = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bus.iAddr = addr;
        bus.iRead = 1'b1;
        exp_q.push_back({exp_resp, exp_data});
        due_q.push_back(cyc + 1);
        @(negedge clk);
        bus.iRead = 1'b0;
    endtask

    task automatic bus_rw(input logic [4:0] addr, input logic [31:0] data, input logic [31:0] exp_data);
        bus.iAddr   = addr;
        bus.iWdata  = data;
        bus.iByteEn = 4'hF;
        bus.iWrite  = 1'b1;
        bus.iRead   = 1'b1;
        exp_q.push_back({2'b00, exp_data});
        due_q.push_back(cyc + 1);
        @(negedge clk);
        bus.iWrite  = 1'b0;
        bus.iRead   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] sts0, sts1;

    initial begin
        rst_n       = 1'b0;
        bus.iAddr   = '0;
        bus.iRead   = 1'b0;
        bus.iWrite  = 1'b0;
        bus.iWdata  = '0;
        bus.iByteEn = '0;
        phase_in    = '0;
        freq_refl   = '0;
        stop_in     = '0;
        tick(3);
        rst_n = 1'b1;

        check_val("rst_freq", freq_tgt, 64'd0);
        check_val("rst_pwm", 64'(pwm_cmp), 64'd0);
        check_val("rst_en", 64'(enable), 64'd0);
        check_val("rst_prsc", 64'(pwm_prsc), 64'd0);
        check_val("rst_maxcnt", 64'(pwm_maxcnt), 64'hFFFF_FFFF);
        check_val("rst_phase", 64'(phase_upd), 64'd0);
        check_val("rst_strobes", 64'({latch_freq, latch_phase}), 64'd0);
        check_val("rst_rd", 64'({bus.oRdataValid, bus.oResp, bus.oRdata}), 64'd0);
        check_val("rst_irq", 64'(irq), 64'd0);

        bus_read(5'h06, 32'h0FFF_F000, 2'b00);

        // byte-lane FreqTarget write
        bus_write(5'h00, 32'hAABB_CCDD, 4'b0101);
        check_val("freq_bytes", 64'(freq_tgt[31:0]), 64'h00BB_00DD);
        check_val("freq_strobe", 64'(latch_freq), 64'b01);
        tick();
        check_val("freq_strobe_end", 64'(latch_freq), 64'b00);

        // phase load on channel 1, then a write without the load flag
        bus_write(5'h06, 32'h0000_003C, 4'hF);
        check_val("phase_strobe", 64'(latch_phase), 64'b10);
        check_val("phase_val", 64'(phase_upd[5:3]), 64'h7);
        check_val("ctrl1_maxcnt", 64'(pwm_maxcnt[31:16]), 64'h0);
        tick();
        check_val("phase_strobe_end", 64'(latch_phase), 64'b00);
        bus_write(5'h06, 32'h0000_0008, 4'hF);
        check_val("phase_nostrobe", 64'(latch_phase), 64'b00);
        check_val("phase_hold", 64'(phase_upd[5:3]), 64'h7);

        bus_write(5'h04, 32'h1122_3344, 4'hF);
        check_val("freq1_strobe", 64'(latch_freq), 64'b10);

        // unmapped channel 2
        bus_read(5'h0B, 32'hFFFF_FFFF, 2'b11);
        bus_write(5'h0B, 32'h1234_5678, 4'hF);
        check_val("unmap_freq", freq_tgt, 64'h1122_3344_00BB_00DD);
        check_val("unmap_strobes", 64'({latch_freq, latch_phase}), 64'd0);
        check_val("unmap_maxcnt", 64'(pwm_maxcnt), 64'h0000_FFFF);
        check_val("unmap_phase", 64'(phase_upd), 64'b111_000);
        check_val("unmap_en", 64'(enable), 64'd0);

        bus_write(5'h01, 32'hFFFF_FFFF, 4'hF);
        check_val("pwm_mask", 64'(pwm_cmp), 64'h1FFFF);

        // Control fields, full then lane-1-only
        bus_write(5'h02, 32'h0123_4A81, 4'hF);
        check_val("ctrl_en", 64'(enable), 64'b01);
        check_val("ctrl_prsc", 64'(pwm_prsc), 64'h02A);
        check_val("ctrl_maxcnt", 64'(pwm_maxcnt[15:0]), 64'h1234);
        check_val("ctrl_nostrobe", 64'(latch_phase), 64'b00);
        bus_write(5'h02, 32'hFFFF_FFFF, 4'b0010);
        check_val("ctrl_lane_prsc", 64'(pwm_prsc[5:0]), 64'h3E);
        check_val("ctrl_lane_maxcnt", 64'(pwm_maxcnt[15:0]), 64'h123F);
        check_val("ctrl_lane_en", 64'(enable), 64'b01);
        phase_in = 6'b000_101;
        bus_read(5'h02, 32'h0123_FF95, 2'b00);

        stop_in   = 2'b10;
        freq_refl = 2'b01;
        tick(2);
`ifdef MBLDCM_AVMM_IRQ_EN
        sts0 = 32'hA;
        sts1 = 32'h5;
`else
        sts0 = 32'h2;
        sts1 = 32'h1;
`endif
        // back-to-back reads
        bus_read(5'h00, 32'h00BB_00DD, 2'b00);
        bus_read(5'h01, 32'h0001_FFFF, 2'b00);
        bus_read(5'h03, sts0, 2'b00);
        bus_read(5'h07, sts1, 2'b00);

        // simultaneous read and write returns the old value
        bus_rw(5'h00, 32'hCAFE_F00D, 32'h00BB_00DD);
        check_val("rw_freq", 64'(freq_tgt[31:0]), 64'hCAFE_F00D);
        check_val("rw_strobe", 64'(latch_freq), 64'b01);

`ifdef MBLDCM_AVMM_IRQ_EN
        bus_write(5'h03, 32'hC, 4'b0001);
        bus_write(5'h07, 32'hC, 4'b0001);
        bus_read(5'h03, 32'h2, 2'b00);
        bus_write(5'h02, 32'h1000_0000, 4'b1000);
        check_val("irqen_maxcnt", 64'(pwm_maxcnt[15:0]), 64'h023F);
        check_val("irq_idle", 64'(irq), 64'd0);
        stop_in = 2'b11;
        tick();
        check_val("irq_lag", 64'(irq), 64'd0);
        tick();
        check_val("irq_set", 64'(irq), 64'd1);
        bus_read(5'h03, 32'h7, 2'b00);
        stop_in = 2'b10;
        tick();
        stop_in = 2'b11;
        bus_write(5'h03, 32'h4, 4'b0001);
        bus_read(5'h03, 32'h7, 2'b00);
        check_val("irq_setwins", 64'(irq), 64'd1);
        bus_write(5'h03, 32'h4, 4'b0001);
        check_val("irq_clr_lag", 64'(irq), 64'd1);
        tick();
        check_val("irq_clr", 64'(irq), 64'd0);
        bus_read(5'h03, 32'h3, 2'b00);
        bus_read(5'h02, 32'h1023_FF95, 2'b00);
`else
        bus_write(5'h03, 32'hC, 4'hF);
        bus_read(5'h03, 32'h2, 2'b00);
        bus_write(5'h02, 32'h1000_0000, 4'b1000);
        check_val("noirq_maxcnt", 64'(pwm_maxcnt[15:0]), 64'h023F);
        bus_read(5'h02, 32'h0023_FF95, 2'b00);
        stop_in = 2'b11;
        tick(3);
        check_val("noirq_irq", 64'(irq), 64'd0);
        bus_read(5'h03, 32'h3, 2'b00);
`endif

        tick(3);
        check_val("rd_drain", 64'(exp_q.size()), 64'd0);

        // reset while a read is in flight
        bus.iAddr = 5'h00;
        bus.iRead = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("rstmid_valid", 64'(bus.oRdataValid), 64'd0);
        check_val("rstmid_freq", freq_tgt, 64'd0);
        check_val("rstmid_maxcnt", 64'(pwm_maxcnt), 64'hFFFF_FFFF);
        check_val("rstmid_irq", 64'(irq), 64'd0);
        bus.iRead = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mbldcm_avmm_if_mc.md
# mbldcm_avmm_if_mc

Multi-channel Avalon-MM register interface for the mBldcm BLDC motor controller. It presents up to eight motor channels behind one slave port, each with its own register bank: FreqTarget, PwmCmp, Control and Status. Reads are registered with a fixed one-cycle latency, writes honour byte enables, and update strobes to each channel core are registered. An optional per-channel event/interrupt path is available. The block sits between the system interconnect and `pChannels` motor-core instances.

## Interface
- pChannels, 2, number of motor channels; legal range 1..8.
- iClock  in  1  system clock.
- iReset_n  in  1  reset, asynchronous assert, active-low.
- iAddr  in  5  word address; iAddr[4:2] selects the channel, iAddr[1:0] selects the word (0 FreqTarget, 1 PwmCmp, 2 Control, 3 Status).
- iRead  in  1  read request.
- iWrite  in  1  write request.
- iWdata  in  32  write data.
- iByteEn  in  4  byte enables for iWdata.
- oRdata  out  32  read data, valid with oRdataValid.
- oRdataValid  out  1  read data valid.
- oResp  out  2  response, valid with oRdataValid: 00 OK, 11 DECODE ERROR.
- oFreqTarget  out  32*pChannels  per-channel frequency target; channel n occupies bits [32n+31:32n].
- oLatchFreqTarget  out  pChannels  one-cycle FreqTarget update strobe.
- oPwmCmp  out  17*pChannels  per-channel PWM compare value.
- oEnable  out  pChannels  per-channel enable.
- oPwmPrsc  out  6*pChannels  per-channel PWM prescaler.
- oPwmMaxCnt  out  16*pChannels  per-channel PWM maximum count.
- oPhaseUpdate  out  3*pChannels  per-channel phase value to load.
- oLatchPhaseUpdate  out  pChannels  one-cycle phase load strobe.
- iPhase  in  3*pChannels  current phase of each channel.
- iFreqReflected  in  pChannels  per-channel "frequency reflected" status.
- iStop  in  pChannels  per-channel "motor stopped" status.
- oIrq  out  1  level interrupt (see Configuration).

## Operation
- **Address decode.** A channel number of pChannels or more is unmapped.
  - Writes to an unmapped channel are ignored.
  - Reads from an unmapped channel return 0xFFFFFFFF with oResp=11.
- **FreqTarget (word 0).** Stored 32-bit register; reads return the stored value. Byte lanes are written independently.
- **PwmCmp (word 1).** Bits [16:0]; bits [31:17] read 0.
- **Control (word 2).**
  - Bit 0: enable.
  - Bits [4:2]: phase. Reads return iPhase; writes drive oPhaseUpdate.
  - Bit 5: phase-load flag. Write-only; reads 0.
  - Bits [11:6]: prescaler.
  - Bits [27:12]: maximum count.
  - Bit 28: IRQ enable (IRQ builds only).
  - Unused bits read 0.
  - Each stored bit is updated only when its byte lane is enabled.
- **Status (word 3).** Bit 0 = iStop, bit 1 = iFreqReflected. Bits 2 and 3 are sticky event flags (IRQ builds). All other bits read 0. Writes affect only the sticky flags.
- **Strobes.**
  - oLatchFreqTarget[n] pulses after any mapped write to word 0 of channel n that has at least one byte lane enabled.
  - oLatchPhaseUpdate[n] pulses after a write to word 2 of channel n with iByteEn[0]=1 and iWdata[5]=1. oPhaseUpdate is registered from iWdata[4:2] on that write and holds its value otherwise.
- **Simultaneous iRead and iWrite.** The write takes effect; the read returns the pre-write value.

## Timing
- **Reset values.**
  - All of the following reset to 0: oRdata, oRdataValid, oResp, FreqTarget, PwmCmp, enable, prescaler, phase outputs, all strobes, IRQ enable, sticky flags, oIrq.
  - oPwmMaxCnt resets to 0xFFFF.
- **Read latency.** A read accepted at edge k produces oRdataValid=1 for exactly one cycle after edge k+1, together with oRdata and oResp. Back-to-back reads give back-to-back valid cycles. No wait states.
- **Write timing.** A write is captured at the edge where iWrite=1. The new register value and its strobe both appear in the following cycle. Strobes are high for exactly one cycle. Back-to-back writes give back-to-back strobes.
- **Reset mid-transaction.** When reset asserts, all outputs go to their reset values immediately. A pending read's valid is dropped.

## Configuration
- **MBLDCM_AVMM_IRQ_EN defined.**
  - Per-channel edge detectors on iStop and iFreqReflected; the previous-value registers reset to 1.
  - A rising edge of iStop sets sticky Status bit 2. A rising edge of iFreqReflected sets sticky Status bit 3.
  - Writing 1 to a sticky bit, with iByteEn[0]=1, clears it. If a set and a clear happen in the same cycle, the set wins.
  - oIrq is registered: it equals the OR over channels of (Control bit 28 AND (bit 2 OR bit 3)), and updates one cycle after the flags change.
- **MBLDCM_AVMM_IRQ_EN undefined.** No edge-detection logic is built. Control bit 28 and Status bits [3:2] read 0, and oIrq is constant 0.

## Test plan
- **Reset and read-back.** Reset, then read channel 1 Control -> after one cycle oRdataValid=1, oRdata=0x0FFFF000 with iPhase[5:3]=0, oResp=00.
- **FreqTarget byte write.** Channel 0 FreqTarget holds 0; write 0xAABBCCDD with iByteEn=0101 -> oFreqTarget[31:0]=0x00BB00DD and oLatchFreqTarget=01 for exactly one cycle after the write.
- **Phase load.** Write Control of channel 1 with 0x0000003C -> next cycle oLatchPhaseUpdate[1]=1 and oPhaseUpdate[5:3]=3'b111. Repeat with bit 5=0 -> no strobe.
- **Unmapped channel.** With pChannels=2, read iAddr=5'h0B (channel 2) -> oRdata=0xFFFFFFFF, oResp=11. A write to that address changes no output.
- **Interrupt path (IRQ build).** Set Control bit 28 on channel 0, raise iStop[0] -> Status bit 2 = 1 and oIrq=1. Write 0x4 to Status in the same cycle as a new iStop rising edge -> flag stays 1. A later write of 0x4 -> flag 0 and oIrq=0 one cycle after.
- **Back-to-back reads.** Issue three consecutive reads (FreqTarget, PwmCmp, Status) -> three consecutive valid cycles with data in request order.
